// File: rtl/truth_table_sequencer_pkg.sv
// rtl/truth_table_sequencer_pkg.sv - shared types, widths and helpers for the truth-table sequencer
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int CNT_W       = 8;
  localparam int IDX_W       = 2;

  // Lowest set bit of the mismatch mask; an all-clear mask reports vector 0.
  function automatic logic [IDX_W-1:0] first_set(input logic [NUM_VECTORS-1:0] mask);
    logic [IDX_W-1:0] pos;
    pos = '0;
    for (int k = NUM_VECTORS - 1; k >= 0; k--) begin
      if (mask[k]) pos = IDX_W'(k);
    end
    return pos;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// rtl/truth_table_sequencer_if.sv - control, status and circuit-drive signals of the sequencer
interface truth_table_sequencer_if;
  import truth_table_sequencer_pkg::*;

  logic                   start;
  logic                   abort;
  logic                   A_0;
  logic                   B_0;
  logic                   C_0;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [NUM_VECTORS-1:0] mismatch_mask;
  logic [IDX_W-1:0]       first_fail;

  // Sequencer side: takes requests and the circuit output, drives the circuit and status.
  modport slave (
    input  start, abort, C_0,
    output A_0, B_0, busy, done, pass, mismatch_mask, first_fail
  );

  // Host/circuit side: issues requests, supplies C, observes drive and status.
  modport master (
    output start, abort, C_0,
    input  A_0, B_0, busy, done, pass, mismatch_mask, first_fail
  );

endinterface

// File: rtl/truth_table_sequencer_settle_counter.sv
// rtl/truth_table_sequencer_settle_counter.sv - loadable up/down counter with terminal-count flag
module settle_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up,
  input  logic [WIDTH-1:0] terminal,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Load wins over counting so a caller can restart the window on the terminal edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= up ? count + 1'b1 : count - 1'b1;
    end
  end

  assign tc = (count == terminal);

endmodule

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps A/B through all vectors and checks C against a truth table
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int                     SETTLE_CYCLES = 4,
  parameter logic [NUM_VECTORS-1:0] EXPECTED      = 4'b0110
) (
  input  logic                    clock,
  input  logic                    reset,
  truth_table_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_t                 state;
  state_t                 state_next;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_next;
  logic [NUM_VECTORS-1:0] mask_next;
  logic                   cnt_tc;
  logic                   cnt_load;
  logic                   launch;
  logic                   sample;
  logic                   last_sample;

  // Abort outranks both a new start and the sample/advance of the current vector.
  assign launch      = (state == IDLE) && bus.start && !bus.abort;
  assign sample      = (state == DRIVE) && cnt_tc && !bus.abort;
  assign last_sample = sample && (idx == LAST_IDX);
  assign cnt_load    = (state != DRIVE) || bus.abort || cnt_tc;

  settle_counter #(
    .WIDTH (CNT_W)
  ) u_settle (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value ('0),
    .enable     (state == DRIVE),
    .up         (1'b1),
    .terminal   (TERMINAL),
    .tc         (cnt_tc)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: IDLE -> DRIVE on start, DRIVE -> DONE after the last sample, DONE lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = DRIVE;
      DRIVE:   if (bus.abort) state_next = IDLE;
               else if (last_sample) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded status outputs.
  always_comb begin
    bus.busy = (state == DRIVE);
    bus.done = (state == DONE);
  end

  // Vector index and mask for the coming cycle; the mask bit of the current vector is set on its sample edge.
  always_comb begin
    idx_next  = idx;
    mask_next = bus.mismatch_mask;
    if (launch || bus.abort) begin
      idx_next = '0;
    end else if (sample) begin
      idx_next = last_sample ? '0 : idx + 1'b1;
    end
    if (launch) begin
      mask_next = '0;
    end else if (sample) begin
      mask_next[idx] = bus.C_0 ^ EXPECTED[idx];
    end
  end

  // Registered circuit drive and results; verdict is taken from the mask including the final sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx               <= '0;
      bus.A_0           <= 1'b0;
      bus.B_0           <= 1'b0;
      bus.mismatch_mask <= '0;
      bus.pass          <= 1'b0;
      bus.first_fail    <= '0;
    end else begin
      idx               <= idx_next;
      bus.A_0           <= (state_next == DRIVE) && idx_next[1];
      bus.B_0           <= (state_next == DRIVE) && idx_next[0];
      bus.mismatch_mask <= mask_next;
      if (launch) begin
        bus.pass       <= 1'b0;
        bus.first_fail <= '0;
      end else if (last_sample) begin
        bus.pass       <= (mask_next == '0);
        bus.first_fail <= first_set(mask_next);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - directed self-checking bench for truth_table_sequencer
module tb_truth_table_sequencer;

  logic clock = 1'b0;
  logic reset;
  int   mode4;
  int   mode1;
  int   checks;
  int   passed;

  always #5 clock = ~clock;

  truth_table_sequencer_if bus4 ();
  truth_table_sequencer_if bus1 ();

  // Circuit under test: 0 = XOR, 1 = stuck at 0, 2 = AND.
  function automatic logic circuit(input int m, input logic a, input logic b);
    case (m)
      0:       return a ^ b;
      1:       return 1'b0;
      default: return a & b;
    endcase
  endfunction

  assign bus4.C_0 = circuit(mode4, bus4.A_0, bus4.B_0);
  assign bus1.C_0 = circuit(mode1, bus1.A_0, bus1.B_0);

  truth_table_sequencer #(.SETTLE_CYCLES(4), .EXPECTED(4'b0110)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  truth_table_sequencer #(.SETTLE_CYCLES(1), .EXPECTED(4'b0110)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse start for one edge (t0) and return the cycle index of the done pulse, 0 on timeout.
  task automatic start_and_wait4(output int lat);
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus4.done === 1'b1) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic start_and_wait1(output int lat);
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (bus1.done === 1'b1) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus4.start = 1'b0; bus4.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    mode4 = 0; mode1 = 0;
    tick(); tick();
    checks++;
    if ({bus4.A_0, bus4.B_0, bus4.busy, bus4.done, bus4.pass, bus4.mismatch_mask, bus4.first_fail} !== 11'd0)
      $display("FAIL reset_outputs_s4 got %b want 0", {bus4.A_0, bus4.B_0, bus4.busy, bus4.done, bus4.pass, bus4.mismatch_mask, bus4.first_fail});
    else passed++;
    checks++;
    if ({bus1.A_0, bus1.B_0, bus1.busy, bus1.done, bus1.pass, bus1.mismatch_mask, bus1.first_fail} !== 11'd0)
      $display("FAIL reset_outputs_s1 got %b want 0", {bus1.A_0, bus1.B_0, bus1.busy, bus1.done, bus1.pass, bus1.mismatch_mask, bus1.first_fail});
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_xor();
    int errs;
    logic [1:0] want;
    mode4 = 0;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    errs = 0;
    for (int c = 1; c <= 16; c++) begin
      want = 2'((c - 1) / 4);
      if ({bus4.A_0, bus4.B_0} !== want || bus4.busy !== 1'b1 || bus4.done !== 1'b0) errs++;
      tick();
    end
    checks++;
    if (errs !== 0) $display("FAIL xor_ab_sequence got %0d bad cycles want 0", errs);
    else passed++;
    checks++;
    if ({bus4.done, bus4.busy, bus4.A_0, bus4.B_0} !== 4'b1000)
      $display("FAIL xor_done_t17 got done,busy,A,B=%b want 1000", {bus4.done, bus4.busy, bus4.A_0, bus4.B_0});
    else passed++;
    checks++;
    if ({bus4.pass, bus4.mismatch_mask, bus4.first_fail} !== 7'b1_0000_00)
      $display("FAIL xor_result got pass,mask,ff=%b want 1000000", {bus4.pass, bus4.mismatch_mask, bus4.first_fail});
    else passed++;
    tick();
    checks++;
    if (bus4.done !== 1'b0) $display("FAIL xor_done_one_cycle got %b want 0", bus4.done);
    else passed++;
  endtask

  task automatic test_stuck();
    int lat;
    mode4 = 1;
    start_and_wait4(lat);
    checks++;
    if (lat !== 17) $display("FAIL stuck_latency got %0d want 17", lat);
    else passed++;
    checks++;
    if ({bus4.pass, bus4.mismatch_mask, bus4.first_fail} !== 7'b0_0110_01)
      $display("FAIL stuck_result got pass,mask,ff=%b want 0011001", {bus4.pass, bus4.mismatch_mask, bus4.first_fail});
    else passed++;
    tick();
  endtask

  task automatic test_and();
    int lat;
    mode4 = 2;
    start_and_wait4(lat);
    checks++;
    if (lat !== 17) $display("FAIL and_latency got %0d want 17", lat);
    else passed++;
    checks++;
    if ({bus4.pass, bus4.mismatch_mask, bus4.first_fail} !== 7'b0_1110_01)
      $display("FAIL and_result got pass,mask,ff=%b want 0111001", {bus4.pass, bus4.mismatch_mask, bus4.first_fail});
    else passed++;
    tick();
    mode4 = 0;
  endtask

  task automatic test_abort();
    int dones;
    int lat;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if ({bus4.A_0, bus4.B_0} !== 2'b10) $display("FAIL abort_pre_vector got %b want 10", {bus4.A_0, bus4.B_0});
    else passed++;
    bus4.abort = 1'b1;
    tick();
    bus4.abort = 1'b0;
    checks++;
    if ({bus4.busy, bus4.A_0, bus4.B_0} !== 3'b000)
      $display("FAIL abort_idle got busy,A,B=%b want 000", {bus4.busy, bus4.A_0, bus4.B_0});
    else passed++;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus4.done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) $display("FAIL abort_no_done got %0d pulses want 0", dones);
    else passed++;
    checks++;
    if (bus4.pass !== 1'b0) $display("FAIL abort_pass got %b want 0", bus4.pass);
    else passed++;
    start_and_wait4(lat);
    checks++;
    if (lat !== 17 || bus4.pass !== 1'b1) $display("FAIL abort_restart got lat=%0d pass=%b want 17 1", lat, bus4.pass);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus4.A_0, bus4.B_0, bus4.busy, bus4.done, bus4.pass, bus4.mismatch_mask, bus4.first_fail} !== 11'd0)
      $display("FAIL async_reset got %b want 0", {bus4.A_0, bus4.B_0, bus4.busy, bus4.done, bus4.pass, bus4.mismatch_mask, bus4.first_fail});
    else passed++;
    tick();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus4.done === 1'b1 || bus4.busy === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) $display("FAIL reset_stays_idle got %0d active cycles want 0", dones);
    else passed++;
  endtask

  task automatic test_start_ignored();
    int dones;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus4.start = 1'b1;
    tick(); tick();
    bus4.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus4.done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones !== 1) $display("FAIL start_while_busy got %0d done pulses want 1", dones);
    else passed++;
  endtask

  task automatic test_settle1();
    int errs;
    int lat;
    int pos[$];
    mode1 = 0;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    errs = 0;
    for (int c = 1; c <= 4; c++) begin
      if ({bus1.A_0, bus1.B_0} !== 2'(c - 1) || bus1.busy !== 1'b1) errs++;
      tick();
    end
    checks++;
    if (errs !== 0) $display("FAIL s1_ab_sequence got %0d bad cycles want 0", errs);
    else passed++;
    checks++;
    if ({bus1.done, bus1.pass, bus1.mismatch_mask} !== 6'b11_0000)
      $display("FAIL s1_done_t5 got done,pass,mask=%b want 110000", {bus1.done, bus1.pass, bus1.mismatch_mask});
    else passed++;
    tick(); tick();
    start_and_wait1(lat);
    checks++;
    if (lat !== 5) $display("FAIL s1_latency got %0d want 5", lat);
    else passed++;
    bus1.start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus1.done === 1'b1) pos.push_back(c);
    end
    bus1.start = 1'b0;
    checks++;
    if (pos.size() !== 3) $display("FAIL s1_b2b_count got %0d pulses want 3", pos.size());
    else passed++;
    if (pos.size() >= 3) begin
      checks++;
      if (pos[0] !== 6 || pos[1] - pos[0] !== 6 || pos[2] - pos[1] !== 6)
        $display("FAIL s1_b2b_spacing got %0d,%0d,%0d want 6,12,18", pos[0], pos[1], pos[2]);
      else passed++;
    end
    for (int i = 0; i < 10; i++) tick();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_xor();
    test_stuck();
    test_and();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    test_settle1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
